sound_mix_scheduler: RTL and testbench



---
 rtl/sound_pkg.sv | 14 +
 rtl/sound_mix_accum.sv | 43 ++++
 rtl/sound_mix_scheduler.sv | 124 ++++++++++++
 tb/tb_sound_mix_scheduler.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sound_pkg.sv
// Shared definitions for the sound players and the mix scheduler: FSM encoding
// and the default sample widths both sides must agree on.
package sound_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2
  } state_t;

  localparam int SAMPLE_W_DEF = 10;
  localparam int OUT_W_DEF    = 32;

endpackage

// File: rtl/sound_mix_accum.sv
// Mix accumulator: sums sign-extended player samples and presents the sum
// shifted into codec sample format.
module sound_mix_accum #(
  parameter int SAMPLE_W   = 10,
  parameter int ACC_W      = 12,
  parameter int OUT_W      = 32,
  parameter int GAIN_SHIFT = 20
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                clear,
  input  logic                add,
  input  logic [SAMPLE_W-1:0] sample,
  output logic [OUT_W-1:0]    codec_sample
);

  logic signed [ACC_W-1:0] acc_p0;

  function automatic logic signed [ACC_W-1:0] sext_sample(input logic [SAMPLE_W-1:0] s);
    return {{(ACC_W-SAMPLE_W){s[SAMPLE_W-1]}}, s};
  endfunction

  // Width is sized so the shifted sum always fits; no saturation required.
  function automatic logic [OUT_W-1:0] format_out(input logic signed [ACC_W-1:0] a);
    logic [OUT_W-1:0] ext;
    ext = {{(OUT_W-ACC_W){a[ACC_W-1]}}, a};
    return ext << GAIN_SHIFT;
  endfunction

  // Stage p0: running frame sum
  always_ff @(posedge clock) begin
    if (reset) begin
      acc_p0 <= '0;
    end else if (clear) begin
      acc_p0 <= '0;
    end else if (add) begin
      acc_p0 <= acc_p0 + sext_sample(sample);
    end
  end

  assign codec_sample = format_out(acc_p0);

endmodule

// File: rtl/sound_mix_scheduler.sv
// Time-shares the codec write port among NUM_CH sound players: polls each active
// player once per frame, sums the collected samples and writes one mixed sample.
module sound_mix_scheduler
  import sound_pkg::*;
#(
  parameter int NUM_CH     = 3,
  parameter int SAMPLE_W   = SAMPLE_W_DEF,
  parameter int OUT_W      = OUT_W_DEF,
  parameter int GAIN_SHIFT = 20,
  parameter int TIMEOUT    = 1023
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_CH-1:0]          ch_req,
  input  logic [NUM_CH-1:0]          ch_valid,
  input  logic [NUM_CH*SAMPLE_W-1:0] ch_sample,
  output logic [NUM_CH-1:0]          ch_allowed,
  input  logic                       codec_allowed,
  output logic                       codec_write,
  output logic [OUT_W-1:0]           codec_sample,
  output logic                       codec_clear,
  output logic                       busy
);

  localparam int IDX_W   = $clog2(NUM_CH);
  localparam int ACC_W   = SAMPLE_W + $clog2(NUM_CH);
  localparam int TIMER_W = $clog2(TIMEOUT + 1);

  state_t              state;
  logic [IDX_W-1:0]    idx;
  logic [NUM_CH-1:0]   mask;
  logic [TIMER_W-1:0]  timer;

  logic                granted;
  logic                strobe;
  logic                timed_out;
  logic                advance;
  logic                last_ch;
  logic                write_now;
  logic                acc_clear;
  logic                acc_add;
  logic [SAMPLE_W-1:0] cur_sample;

  assign granted    = (state == COLLECT) && mask[idx];
  assign strobe     = granted && ch_valid[idx];
  assign timed_out  = granted && (timer == TIMER_W'(TIMEOUT - 1));
  // Unrequested channels cost one cycle; granted ones wait for a strobe or timeout.
  assign advance    = (state == COLLECT) && (!mask[idx] || strobe || timed_out);
  assign last_ch    = (idx == IDX_W'(NUM_CH - 1));
  assign write_now  = (state == WRITE) && codec_allowed;
  assign cur_sample = ch_sample[int'(idx)*SAMPLE_W +: SAMPLE_W];

  assign acc_clear = ((state == IDLE) || write_now) && (|ch_req);
  assign acc_add   = strobe;

  always_comb begin
    ch_allowed = '0;
    if (granted) ch_allowed[idx] = 1'b1;
  end

  assign codec_write = write_now;
  assign busy        = (state != IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      mask        <= '0;
      timer       <= '0;
      codec_clear <= 1'b0;
    end else begin
      codec_clear <= 1'b0;
      case (state)
        IDLE: begin
          if (|ch_req) begin
            mask  <= ch_req;
            idx   <= '0;
            timer <= '0;
            state <= COLLECT;
          end
        end
        COLLECT: begin
          if (advance) begin
            timer <= '0;
            if (last_ch) state <= WRITE;
            else         idx   <= idx + IDX_W'(1);
          end else begin
            timer <= timer + TIMER_W'(1);
          end
        end
        WRITE: begin
          if (codec_allowed) begin
            if (|ch_req) begin
              mask  <= ch_req;
              idx   <= '0;
              timer <= '0;
              state <= COLLECT;
            end else begin
              idx         <= '0;
              state       <= IDLE;
              codec_clear <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  sound_mix_accum #(
    .SAMPLE_W   (SAMPLE_W),
    .ACC_W      (ACC_W),
    .OUT_W      (OUT_W),
    .GAIN_SHIFT (GAIN_SHIFT)
  ) u_accum (
    .clock        (clock),
    .reset        (reset),
    .clear        (acc_clear),
    .add          (acc_add),
    .sample       (cur_sample),
    .codec_sample (codec_sample)
  );

endmodule

// File: tb/tb_sound_mix_scheduler.sv
// Scoreboard bench for sound_mix_scheduler: behavioural players answer grants,
// expected mixed samples are queued per scenario and matched against codec writes.
module tb_sound_mix_scheduler;

  localparam int NUM_CH     = 3;
  localparam int SAMPLE_W   = 10;
  localparam int OUT_W      = 32;
  localparam int GAIN_SHIFT = 20;
  localparam int TIMEOUT    = 1023;

  logic                       clock = 1'b0;
  logic                       reset;
  logic [NUM_CH-1:0]          ch_req;
  logic [NUM_CH-1:0]          ch_valid = '0;
  logic [NUM_CH*SAMPLE_W-1:0] ch_sample;
  logic [NUM_CH-1:0]          ch_allowed;
  logic                       codec_allowed;
  logic                       codec_write;
  logic [OUT_W-1:0]           codec_sample;
  logic                       codec_clear;
  logic                       busy;

  always #5 clock = ~clock;

  sound_mix_scheduler #(
    .NUM_CH     (NUM_CH),
    .SAMPLE_W   (SAMPLE_W),
    .OUT_W      (OUT_W),
    .GAIN_SHIFT (GAIN_SHIFT),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .ch_req        (ch_req),
    .ch_valid      (ch_valid),
    .ch_sample     (ch_sample),
    .ch_allowed    (ch_allowed),
    .codec_allowed (codec_allowed),
    .codec_write   (codec_write),
    .codec_sample  (codec_sample),
    .codec_clear   (codec_clear),
    .busy          (busy)
  );

  // Player configuration, owned by the stimulus process
  logic [NUM_CH-1:0]          req_cfg = '0;
  int                         req_gen = 0;
  int                         stop_at = -1;
  logic signed [SAMPLE_W-1:0] samp [NUM_CH];
  int                         dly  [NUM_CH];

  // Monitor-owned state
  bit               stopped = 1'b0;
  int               stop_gen = 0;
  int               cyc = 0;
  int               write_cnt = 0;
  int               clear_cnt = 0;
  int               multi_cnt = 0;
  int               last_wr_cyc = 0;
  int               wr_interval = 0;
  int               gcnt [NUM_CH];
  int               last_run [NUM_CH];
  logic [OUT_W-1:0] obs [$];

  // Requests drop automatically once the last expected write of a scenario is seen.
  assign ch_req = (stopped && stop_gen == req_gen) ? '0 : req_cfg;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_samp
    assign ch_sample[c*SAMPLE_W +: SAMPLE_W] = samp[c];
  end

  always @(negedge clock) begin
    cyc++;
    if ($countones(ch_allowed) > 1) multi_cnt++;
    if (codec_clear) clear_cnt++;
    if (codec_write) begin
      obs.push_back(codec_sample);
      write_cnt++;
      wr_interval = cyc - last_wr_cyc;
      last_wr_cyc = cyc;
      if (write_cnt == stop_at) begin
        stopped  = 1'b1;
        stop_gen = req_gen;
      end
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_allowed[c]) begin
        gcnt[c]++;
      end else begin
        if (gcnt[c] != 0) last_run[c] = gcnt[c];
        gcnt[c] = 0;
      end
      ch_valid[c] = ch_allowed[c] && (dly[c] >= 0) && (gcnt[c] > dly[c]);
    end
  end

  int               n_checks = 0;
  int               n_pass = 0;
  int               rd = 0;
  logic [OUT_W-1:0] sb [$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic set_req(input logic [NUM_CH-1:0] v);
    req_cfg = v;
    req_gen++;
  endtask

  task automatic expect_frames(input int n, input logic [OUT_W-1:0] val);
    for (int i = 0; i < n; i++) sb.push_back(val);
    stop_at = write_cnt + n;
  endtask

  function automatic logic [OUT_W-1:0] mix(input int sum);
    logic [OUT_W-1:0] v;
    v = OUT_W'(sum);
    return v << GAIN_SHIFT;
  endfunction

  task automatic drain(input string tag, input int bound);
    int k;
    logic [OUT_W-1:0] e;
    k = 0;
    while (sb.size() > 0 && k < bound) begin
      @(negedge clock);
      k++;
      while (rd < obs.size() && sb.size() > 0) begin
        e = sb.pop_front();
        check_eq(tag, obs[rd], e);
        rd++;
      end
    end
    if (sb.size() != 0) begin
      check_eq({tag, " missing writes"}, sb.size(), 0);
      sb.delete();
    end
    tick(4);
    check_eq({tag, " extra writes"}, obs.size() - rd, 0);
    rd = obs.size();
  endtask

  int c0, m0, w0, g0, wh;

  initial begin
    for (int c = 0; c < NUM_CH; c++) begin
      samp[c] = '0;
      dly[c]  = 0;
    end
    reset         = 1'b1;
    codec_allowed = 1'b1;
    tick(3);
    check_eq("reset ch_allowed", ch_allowed, 0);
    check_eq("reset codec_write", codec_write, 0);
    check_eq("reset codec_sample", codec_sample, 0);
    check_eq("reset codec_clear", codec_clear, 0);
    check_eq("reset busy", busy, 0);
    reset = 1'b0;
    tick(2);

    // Single channel, strobe one cycle after grant
    samp[0] = 10'sd5; dly[0] = 1;
    c0 = clear_cnt;
    expect_frames(3, 32'h0050_0000);
    set_req(3'b001);
    drain("single", 200);
    check_eq("single grant len", last_run[0], 2);
    check_eq("single frame period", wr_interval, 5);
    check_eq("single clear pulses", clear_cnt - c0, 1);

    // Three channels, all ready at once
    samp[0] = 10'sd3; samp[1] = -10'sd1; samp[2] = 10'sd2;
    dly[0] = 0; dly[1] = 0; dly[2] = 0;
    m0 = multi_cnt;
    expect_frames(3, 32'h0040_0000);
    set_req(3'b111);
    drain("three", 200);
    check_eq("three multi grant", multi_cnt - m0, 0);
    check_eq("three frame period", wr_interval, NUM_CH + 1);
    check_eq("three grant len ch1", last_run[1], 1);

    // Channel 1 never answers
    samp[0] = 10'sd7; dly[0] = 0; dly[1] = -1;
    expect_frames(2, mix(7));
    set_req(3'b011);
    drain("timeout", 5000);
    check_eq("timeout grant len", last_run[1], TIMEOUT);

    // Strobe on the very cycle the timeout fires
    samp[1] = -10'sd3; dly[1] = TIMEOUT - 1;
    expect_frames(1, mix(4));
    set_req(3'b011);
    drain("late strobe", 3000);
    check_eq("late strobe grant len", last_run[1], TIMEOUT);

    // Every requested channel times out
    samp[0] = 10'sd9; dly[0] = -1;
    expect_frames(1, 32'h0000_0000);
    set_req(3'b001);
    drain("all timeout", 3000);

    // Codec back-pressure
    @(posedge clock); #1 codec_allowed = 1'b0;
    samp[0] = 10'sd1; dly[0] = 0;
    @(negedge clock);
    expect_frames(1, mix(1));
    set_req(3'b001);
    tick(10);
    w0 = write_cnt; g0 = 0; wh = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (ch_allowed != 0) g0++;
      if (codec_write) wh++;
    end
    check_eq("bp writes held", wh, 0);
    check_eq("bp grants held", g0, 0);
    check_eq("bp busy held", busy, 1);
    @(posedge clock); #1 codec_allowed = 1'b1;
    drain("bp", 100);
    check_eq("bp write count", write_cnt - w0, 1);

    // Requests withdrawn mid-frame
    samp[0] = 10'sd1; samp[1] = 10'sd2; samp[2] = 10'sd3;
    dly[0] = 2; dly[1] = 2; dly[2] = 2;
    c0 = clear_cnt; w0 = write_cnt;
    expect_frames(1, mix(6));
    set_req(3'b111);
    tick(2);
    set_req(3'b000);
    drain("drop", 200);
    check_eq("drop write count", write_cnt - w0, 1);
    check_eq("drop clear pulse len", clear_cnt - c0, 1);
    check_eq("drop busy", busy, 0);
    check_eq("drop clear idle", codec_clear, 0);

    // Reset in the middle of collection
    samp[0] = 10'sd9; samp[1] = 10'sd1;
    dly[0] = 0; dly[1] = -1;
    set_req(3'b011);
    tick(6);
    check_eq("mid grant ch1", ch_allowed, 3'b010);
    w0 = write_cnt;
    reset = 1'b1;
    @(negedge clock);
    check_eq("mid reset ch_allowed", ch_allowed, 0);
    check_eq("mid reset codec_write", codec_write, 0);
    check_eq("mid reset codec_sample", codec_sample, 0);
    check_eq("mid reset codec_clear", codec_clear, 0);
    check_eq("mid reset busy", busy, 0);
    tick(2);
    check_eq("mid reset no write", write_cnt - w0, 0);
    dly[1] = 0;
    expect_frames(1, mix(10));
    reset = 1'b0;
    drain("after reset", 200);
    check_eq("after reset write count", write_cnt - w0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
